// File: rtl/sum_win_pkg.sv
// Shared types and helpers for the window accumulator slice.
package sum_win_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_WINDOW = 8;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sum_window_accumulator_win_counter.sv
// Sample counter for one window; 'last' flags the final sample slot.
module win_counter
  import sum_win_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load1,
  input  logic clr,
  output logic last
);

  localparam int CNT_W = clog2(WINDOW);

  logic [CNT_W-1:0] cnt;

  // A completing increment wraps to zero because WINDOW is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (load1) cnt <= CNT_W'(1);
    else if (inc)   cnt <= cnt + CNT_W'(1);
  end

  assign last = (cnt == CNT_W'(WINDOW - 1));

endmodule

// File: rtl/sum_window_accumulator.sv
// Accumulates WINDOW samples and presents the total on a valid/ready port.
// Define SUM_WIN_AVG_EN to output the window average instead of the sum.
module sum_window_accumulator
  import sum_win_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ACC_W  = DATA_W + clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int CNT_W = clog2(WINDOW);

  if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
    $error("sum_window_accumulator: WINDOW must be a power of two and >= 2");
  end

  state_t           state, next_state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] sum;
  logic             accept;
  logic             last;
  logic             cnt_inc, cnt_load1, cnt_clr;
  logic             complete;

  assign sample = ACC_W'(in_data);
  assign sum    = acc + sample;

  win_counter #(.WINDOW(WINDOW)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ACCUM;
      ACCUM:   if (accept && last) next_state = HOLD;
      HOLD:    if (out_ready) next_state = in_valid ? ACCUM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD) || out_ready;
    accept    = in_valid && in_ready;
    cnt_inc   = accept && (state == ACCUM);
    cnt_load1 = accept && (state != ACCUM);
    cnt_clr   = (state == HOLD) && out_ready && !in_valid;
    complete  = accept && (state == ACCUM) && last;
  end

  // The first sample of a window (from IDLE or a zero-bubble HOLD exit) reloads acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept) acc <= (state == ACCUM) ? sum : sample;
      if (complete) begin
        out_valid <= 1'b1;
`ifdef SUM_WIN_AVG_EN
        out_data  <= sum >> CNT_W;
`else
        out_data  <= sum;
`endif
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == HOLD && !out_ready && in_valid) overrun <= 1'b1;
    end
  end

endmodule
